rfsh_dma_arbiter: RTL and testbench

RFSH_DMA_ARBITER -- requirements
Module: rfsh_dma_arbiter

---
 rtl/zx_pkg.sv | 15 +
 rtl/rr_pick.sv | 34 +++
 rtl/rfsh_dma_arbiter.sv | 138 +++++++++++++
 tb/tb_rfsh_dma_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/zx_pkg.sv
// Shared definitions for the refresh-window DMA arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package zx_pkg;

  // Arbiter sequencer states: waiting for a refresh window, or owning the SDRAM port
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } arb_state_t;

  // Default cycles from access start to SDRAM data capture
  localparam int ACK_DELAY_DEF = 7;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester strictly after the last-granted channel wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides whether to act on the grant.
module rr_pick #(
  parameter int NCH = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] ptr,
  output logic [NCH-1:0] grant,
  output logic           valid
);

  int base;
  int idx;

  // Locate last grant, then scan the ring starting one past it
  always_comb begin
    grant = '0;
    valid = 1'b0;
    base  = 0;
    idx   = 0;
    for (int i = 0; i < NCH; i++) begin
      if (ptr[i]) base = i;
    end
    for (int k = 1; k <= NCH; k++) begin
      idx = (base + k) % NCH;
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rfsh_dma_arbiter.sv
// Steals CPU refresh windows to run one byte-wide SDRAM access per window for NCH channels.
// Latency: grant on the edge after nRFSH falls; completion ACK_DELAY cycles later.
// Backpressure: none; requests not granted in a window are dropped, no queuing.
module rfsh_dma_arbiter
  import zx_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int AW        = 25,
  parameter int ACK_DELAY = ACK_DELAY_DEF
) (
  input  logic              clk_sys,
  input  logic              nRESET,
  input  logic              nRFSH,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_we,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*8-1:0]  ch_wdata,
  output logic [7:0]        ch_rdata,
  output logic [NCH-1:0]    ch_done,
  output logic              mem_act,
  output logic [AW-1:0]     mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_rd,
  output logic              mem_we,
  input  logic [7:0]        mem_dout
);

  // Pointer resets to the top channel so channel 0 is searched first
  localparam logic [NCH-1:0] PTR_RST = NCH'(1) << (NCH - 1);

  arb_state_t     state;
  logic [3:0]     cnt;
  logic           nrfsh_q;
  logic           win_start;
  logic [NCH-1:0] ptr;
  logic [NCH-1:0] gnt;
  logic           g_we;
  logic [NCH-1:0] elig;
  logic [NCH-1:0] pick;
  logic           pick_vld;
  logic [AW-1:0]  sel_addr;
  logic [7:0]     sel_wdata;
  logic           sel_we;
  logic [AW-1:0]  cache [NCH];

  assign win_start = nrfsh_q & ~nRFSH;

  // Reads of the address last fetched by that channel are redundant; writes always go
  for (genvar g = 0; g < NCH; g++) begin : g_elig
    assign elig[g] = ch_req[g] & (ch_we[g] | (ch_addr[g*AW +: AW] != cache[g]));
  end

  rr_pick #(.NCH(NCH)) u_pick (
    .req   (elig),
    .ptr   (ptr),
    .grant (pick),
    .valid (pick_vld)
  );

  // Route the picked channel's request fields for latching at grant
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (pick[i]) begin
        sel_addr  = ch_addr[i*AW +: AW];
        sel_wdata = ch_wdata[i*8 +: 8];
        sel_we    = ch_we[i];
      end
    end
  end

  // Sequencer: grant on window start, count down the access, abort if the window closes early
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      nrfsh_q  <= 1'b1;
      ptr      <= PTR_RST;
      gnt      <= '0;
      g_we     <= 1'b0;
      ch_rdata <= '0;
      ch_done  <= '0;
      mem_act  <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_rd   <= 1'b0;
      mem_we   <= 1'b0;
      for (int i = 0; i < NCH; i++) cache[i] <= '1;
    end else begin
      nrfsh_q <= nRFSH;
      ch_done <= '0;
      case (state)
        ST_IDLE: begin
          if (win_start && pick_vld) begin
            state    <= ST_ACCESS;
            cnt      <= 4'(ACK_DELAY);
            gnt      <= pick;
            g_we     <= sel_we;
            mem_act  <= 1'b1;
            mem_addr <= sel_addr;
            mem_din  <= sel_wdata;
            mem_rd   <= ~sel_we;
            mem_we   <= sel_we;
          end
        end
        ST_ACCESS: begin
          if (nRFSH) begin
            // Window closed under us: drop the access without side effects
            state   <= ST_IDLE;
            cnt     <= '0;
            mem_act <= 1'b0;
            mem_rd  <= 1'b0;
            mem_we  <= 1'b0;
          end else if (cnt == 4'd1) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            mem_act <= 1'b0;
            mem_rd  <= 1'b0;
            mem_we  <= 1'b0;
            ch_done <= gnt;
            ptr     <= gnt;
            if (!g_we) begin
              ch_rdata <= mem_dout;
              for (int i = 0; i < NCH; i++) begin
                if (gnt[i]) cache[i] <= mem_addr;
              end
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rfsh_dma_arbiter.sv
module tb_rfsh_dma_arbiter;

  localparam int NCH = 2;
  localparam int AW  = 25;

  logic              clk_sys = 1'b0;
  logic              nRESET  = 1'b1;
  logic              nRFSH   = 1'b1;
  logic [NCH-1:0]    ch_req  = '0;
  logic [NCH-1:0]    ch_we   = '0;
  logic [NCH*AW-1:0] ch_addr = '0;
  logic [NCH*8-1:0]  ch_wdata = '0;
  logic [7:0]        ch_rdata;
  logic [NCH-1:0]    ch_done;
  logic              mem_act;
  logic [AW-1:0]     mem_addr;
  logic [7:0]        mem_din;
  logic              mem_rd;
  logic              mem_we;
  logic [7:0]        mem_dout = '0;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_rdata = 8'h00;

  rfsh_dma_arbiter #(.NCH(NCH), .AW(AW), .ACK_DELAY(7)) dut (
    .clk_sys  (clk_sys),
    .nRESET   (nRESET),
    .nRFSH    (nRFSH),
    .ch_req   (ch_req),
    .ch_we    (ch_we),
    .ch_addr  (ch_addr),
    .ch_wdata (ch_wdata),
    .ch_rdata (ch_rdata),
    .ch_done  (ch_done),
    .mem_act  (mem_act),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_rd   (mem_rd),
    .mem_we   (mem_we),
    .mem_dout (mem_dout)
  );

  always #5 clk_sys = ~clk_sys;

  // Open a refresh window of nlow cycles and tally what the DUT did, sampled on negedges
  task automatic run_window(input int nlow, output int rd_c, output int we_c, output int dn_c,
                            output logic [1:0] dn_or, output logic [24:0] a_seen,
                            output logic [7:0] d_seen);
    rd_c = 0; we_c = 0; dn_c = 0; dn_or = '0; a_seen = '0; d_seen = '0;
    @(negedge clk_sys);
    nRFSH = 1'b0;
    for (int c = 0; c < nlow + 4; c++) begin
      @(negedge clk_sys);
      if (mem_rd) rd_c++;
      if (mem_we) we_c++;
      if (mem_act) begin a_seen = mem_addr; d_seen = mem_din; end
      if (ch_done != '0) begin dn_c++; dn_or = dn_or | ch_done; end
      if (c == nlow - 1) nRFSH = 1'b1;
    end
  endtask

  task automatic test_reset();
    #2 nRESET = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++; if ({mem_act, mem_rd, mem_we} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {mem_act, mem_rd, mem_we}); end
    checks++; if (ch_done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b exp=00", ch_done); end
    checks++; if (ch_rdata !== 8'h00 || mem_addr !== 25'h0 || mem_din !== 8'h00) begin failures++; $display("FAIL reset_data got rdata=%h addr=%h din=%h exp all 0", ch_rdata, mem_addr, mem_din); end
    nRESET = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_read_first();
    int rd, we, dn; logic [1:0] dor; logic [24:0] a; logic [7:0] d;
    ch_req = 2'b01; ch_we = 2'b00; ch_addr[0 +: AW] = 25'h000100; mem_dout = 8'h3C;
    run_window(10, rd, we, dn, dor, a, d);
    exp_rdata = 8'h3C;
    checks++; if (rd !== 7) begin failures++; $display("FAIL read_rd_cycles got=%0d exp=7", rd); end
    checks++; if (we !== 0) begin failures++; $display("FAIL read_we_cycles got=%0d exp=0", we); end
    checks++; if (dn !== 1 || dor !== 2'b01) begin failures++; $display("FAIL read_done got cnt=%0d mask=%b exp cnt=1 mask=01", dn, dor); end
    checks++; if (a !== 25'h000100) begin failures++; $display("FAIL read_addr got=%h exp=000100", a); end
    checks++; if (ch_rdata !== exp_rdata) begin failures++; $display("FAIL read_rdata got=%h exp=%h", ch_rdata, exp_rdata); end
  endtask

  task automatic test_cache_hit();
    int rd, we, dn; logic [1:0] dor; logic [24:0] a; logic [7:0] d;
    mem_dout = 8'hEE;
    run_window(10, rd, we, dn, dor, a, d);
    checks++; if (rd !== 0 || dn !== 0) begin failures++; $display("FAIL cache_hit got rd=%0d done=%0d exp 0 0", rd, dn); end
    checks++; if (ch_rdata !== exp_rdata) begin failures++; $display("FAIL cache_rdata got=%h exp=%h", ch_rdata, exp_rdata); end
  endtask

  task automatic test_abort();
    int rd, we, dn; logic [1:0] dor; logic [24:0] a; logic [7:0] d;
    ch_addr[0 +: AW] = 25'h000400; mem_dout = 8'h77;
    run_window(3, rd, we, dn, dor, a, d);
    checks++; if (rd !== 3 || dn !== 0) begin failures++; $display("FAIL abort got rd=%0d done=%0d exp rd=3 done=0", rd, dn); end
    checks++; if (ch_rdata !== exp_rdata) begin failures++; $display("FAIL abort_rdata got=%h exp=%h", ch_rdata, exp_rdata); end
    mem_dout = 8'h5A;
    run_window(10, rd, we, dn, dor, a, d);
    exp_rdata = 8'h5A;
    checks++; if (rd !== 7 || dor !== 2'b01 || dn !== 1) begin failures++; $display("FAIL abort_regrant got rd=%0d mask=%b cnt=%0d exp 7 01 1", rd, dor, dn); end
    checks++; if (a !== 25'h000400 || ch_rdata !== exp_rdata) begin failures++; $display("FAIL abort_regrant_data got addr=%h rdata=%h exp 000400 %h", a, ch_rdata, exp_rdata); end
  endtask

  task automatic test_write();
    int rd, we, dn; logic [1:0] dor; logic [24:0] a; logic [7:0] d;
    ch_req = 2'b10; ch_we = 2'b10; ch_addr[AW +: AW] = 25'h1FFFFFF; ch_wdata[8 +: 8] = 8'hA5;
    run_window(10, rd, we, dn, dor, a, d);
    checks++; if (we !== 7 || rd !== 0) begin failures++; $display("FAIL write_strobes got we=%0d rd=%0d exp 7 0", we, rd); end
    checks++; if (a !== 25'h1FFFFFF || d !== 8'hA5) begin failures++; $display("FAIL write_addr_din got %h %h exp 1ffffff a5", a, d); end
    checks++; if (dor !== 2'b10 || dn !== 1) begin failures++; $display("FAIL write_done got mask=%b cnt=%0d exp 10 1", dor, dn); end
    // Long window: the repeat is granted, but only once per window
    run_window(20, rd, we, dn, dor, a, d);
    checks++; if (we !== 7 || dn !== 1 || dor !== 2'b10) begin failures++; $display("FAIL write_repeat got we=%0d cnt=%0d mask=%b exp 7 1 10", we, dn, dor); end
    checks++; if (ch_rdata !== exp_rdata) begin failures++; $display("FAIL write_rdata got=%h exp=%h", ch_rdata, exp_rdata); end
  endtask

  task automatic test_round_robin();
    int rd, we, dn; logic [1:0] dor; logic [24:0] a; logic [7:0] d;
    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
    ch_req = 2'b11; ch_we = 2'b11;
    ch_addr[0 +: AW] = 25'h000200; ch_addr[AW +: AW] = 25'h000300;
    ch_wdata[0 +: 8] = 8'h11; ch_wdata[8 +: 8] = 8'h22;
    for (int w = 0; w < 4; w++) begin
      run_window(10, rd, we, dn, dor, a, d);
      checks++; if (dor !== exp_g[w] || dn !== 1 || d !== exp_d[w]) begin failures++; $display("FAIL rr_window%0d got mask=%b cnt=%0d din=%h exp %b 1 %h", w, dor, dn, d, exp_g[w], exp_d[w]); end
    end
  endtask

  task automatic test_reset_mid();
    int rd, we, dn; logic [1:0] dor; logic [24:0] a; logic [7:0] d;
    ch_req = 2'b01; ch_we = 2'b00; ch_addr[0 +: AW] = 25'h000400;
    run_window(10, rd, we, dn, dor, a, d);
    checks++; if (rd !== 0) begin failures++; $display("FAIL mid_precached got rd=%0d exp=0", rd); end
    ch_req = 2'b10; ch_we = 2'b10;
    @(negedge clk_sys); nRFSH = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL mid_active got mem_we=%b exp=1", mem_we); end
    #1 nRESET = 1'b0;
    #1;
    checks++; if ({mem_act, mem_rd, mem_we} !== 3'b000) begin failures++; $display("FAIL mid_reset_strobes got=%b exp=000", {mem_act, mem_rd, mem_we}); end
    nRFSH = 1'b1;
    repeat (2) @(negedge clk_sys);
    checks++; if (ch_done !== 2'b00) begin failures++; $display("FAIL mid_reset_done got=%b exp=00", ch_done); end
    nRESET = 1'b1;
    ch_req = 2'b01; ch_we = 2'b00; mem_dout = 8'h9B;
    run_window(10, rd, we, dn, dor, a, d);
    checks++; if (rd !== 7 || dor !== 2'b01 || dn !== 1) begin failures++; $display("FAIL mid_post_read got rd=%0d mask=%b cnt=%0d exp 7 01 1", rd, dor, dn); end
    checks++; if (ch_rdata !== 8'h9B) begin failures++; $display("FAIL mid_post_rdata got=%h exp=9b", ch_rdata); end
  endtask

  initial begin
    test_reset();
    test_read_first();
    test_cache_hit();
    test_abort();
    test_write();
    test_round_robin();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
